// File: rtl/rvj1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rvj1_mem_arbiter
//
// Shares one memory port between instruction fetch (port 0, read-only) and the
// load-store unit (port 1, read/write). The arbiter picks which requester
// drives the memory request and records the source of every accepted request
// in an ID FIFO. In-order memory responses are then routed back to the
// requester at the FIFO head.
//
// Build option:
//   ARB_DATA_PRIO_EN  defined   -> data port wins whenever both ports request
//                     undefined -> round-robin between the two ports
//                                  (data port favoured first after reset)
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_req_*  / if_rsp_*     fetch request (addr/valid/ready) and response
//   d_req_*   / d_rsp_*      data request (addr/data/strobe/write) and response
//   mem_req_* / mem_rsp_*    shared memory request and in-order response
//   ghost_rsp_o              sticky flag: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module rvj1_mem_arbiter #(
    parameter int XLEN            = 32,
    parameter int NBYTES          = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [XLEN-1:0]   if_req_addr_i,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    output logic [XLEN-1:0]   if_rsp_data_o,
    output logic              if_rsp_error_o,
    output logic              if_rsp_valid_o,
    input  logic              if_rsp_ready_i,

    input  logic [XLEN-1:0]   d_req_addr_i,
    input  logic [XLEN-1:0]   d_req_data_i,
    input  logic [NBYTES-1:0] d_req_strobe_i,
    input  logic              d_req_write_i,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    output logic [XLEN-1:0]   d_rsp_data_o,
    output logic              d_rsp_error_o,
    output logic              d_rsp_valid_o,
    input  logic              d_rsp_ready_i,

    output logic [XLEN-1:0]   mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_data_o,
    output logic [NBYTES-1:0] mem_req_strobe_o,
    output logic              mem_req_write_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    input  logic [XLEN-1:0]   mem_rsp_data_i,
    input  logic              mem_rsp_error_i,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,

    output logic              ghost_rsp_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // Request-side state
    logic             r_lock;
    port_e            r_lock_port;
`ifndef ARB_DATA_PRIO_EN
    port_e            r_last;        // port granted by the most recent fire
`endif

    // Outstanding-ID FIFO
    port_e            r_id_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ghost;

    port_e            w_sel;
    logic             w_sel_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_req_valid;
    logic             w_req_fire;
    port_e            w_head;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);

    // -------------------------------------------------------------------------
    // Grant selection. While locked the stalled selection is held so the
    // presented request never changes before it is accepted.
    // -------------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_sel = PORT_D;
        if (r_lock) begin
            w_sel = r_lock_port;
        end else if (if_req_valid_i && d_req_valid_i) begin
`ifdef ARB_DATA_PRIO_EN
            w_sel = PORT_D;
`else
            w_sel = (r_last == PORT_D) ? PORT_IF : PORT_D;
`endif
        end else if (if_req_valid_i) begin
            w_sel = PORT_IF;
        end
    end

    assign w_sel_valid = (w_sel == PORT_D) ? d_req_valid_i : if_req_valid_i;

    // A full FIFO blocks the grant even if a pop happens this cycle; this keeps
    // the response path from reaching the request handshake combinationally.
    assign w_req_valid = w_sel_valid && !w_full;
    assign w_req_fire  = w_req_valid && mem_req_ready_i;

    assign mem_req_valid_o = w_req_valid;
    assign if_req_ready_o  = w_req_valid && (w_sel == PORT_IF) && mem_req_ready_i;
    assign d_req_ready_o   = w_req_valid && (w_sel == PORT_D)  && mem_req_ready_i;

    // Payload mux: fetches are full-word reads
    always_comb begin
        mem_req_addr_o   = if_req_addr_i;
        mem_req_data_o   = '0;
        mem_req_strobe_o = '1;
        mem_req_write_o  = 1'b0;
        if (w_sel == PORT_D) begin
            mem_req_addr_o   = d_req_addr_i;
            mem_req_data_o   = d_req_data_i;
            mem_req_strobe_o = d_req_strobe_i;
            mem_req_write_o  = d_req_write_i;
        end
    end

    // -------------------------------------------------------------------------
    // Response routing. With nothing outstanding the memory response is drained
    // (ready=1) and flagged as a ghost instead of reaching either requester.
    // -------------------------------------------------------------------------
    assign w_head = r_id_mem[r_rd_ptr];

    assign if_rsp_valid_o  = mem_rsp_valid_i && !w_empty && (w_head == PORT_IF);
    assign d_rsp_valid_o   = mem_rsp_valid_i && !w_empty && (w_head == PORT_D);
    assign mem_rsp_ready_o = w_empty ? 1'b1
                           : ((w_head == PORT_D) ? d_rsp_ready_i : if_rsp_ready_i);
    assign w_pop           = mem_rsp_valid_i && mem_rsp_ready_o && !w_empty;

    assign if_rsp_data_o  = mem_rsp_data_i;
    assign if_rsp_error_o = mem_rsp_error_i;
    assign d_rsp_data_o   = mem_rsp_data_i;
    assign d_rsp_error_o  = mem_rsp_error_i;

    assign ghost_rsp_o = r_ghost;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock      <= 1'b0;
            r_lock_port <= PORT_D;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ghost     <= 1'b0;
        end else begin
            // Lock while a presented request is stalled; a fire releases it
            r_lock      <= w_req_valid && !mem_req_ready_i;
            r_lock_port <= w_sel;

            if (w_req_fire) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_req_fire, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (mem_rsp_valid_i && w_empty) begin
                r_ghost <= 1'b1;
            end
        end
    end

`ifndef ARB_DATA_PRIO_EN
    // Reset value PORT_IF makes the data port win the first contended grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= PORT_IF;
        end else if (w_req_fire) begin
            r_last <= w_sel;
        end
    end
`endif

    // NOTE: FIFO storage is not reset; entries are only read while r_count
    // says they are valid, so clearing the pointers is sufficient.
    always_ff @(posedge clk_i) begin
        if (w_req_fire) begin
            r_id_mem[r_wr_ptr] <= w_sel;
        end
    end

endmodule
